// File: rtl/paddle_motion_ctrl.sv
// Keyboard-driven paddle position controller with per-axis clamping to the player's field.
// Optional acceleration ramp is enabled by defining PADDLE_ACCEL_EN.
module paddle_motion_ctrl #(
  parameter int         X_W      = 10,
  parameter int         Y_W      = 9,
  parameter logic [7:0] KEY_UP   = 8'h1D,
  parameter logic [7:0] KEY_DN   = 8'h1B,
  parameter logic [7:0] KEY_LT   = 8'h1C,
  parameter logic [7:0] KEY_RT   = 8'h23,
  parameter int         SPD_SLOW = 1,
  parameter int         SPD_FAST = 5,
  parameter int         ACC_MAX  = 7
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [7:0]     kb_code,
  input  logic           kb_valid,
  input  logic           move_tick,
  input  logic           play_en,
  input  logic           fast_mode,
  input  logic [X_W-1:0] x_min,
  input  logic [X_W-1:0] x_max,
  input  logic [Y_W-1:0] y_min,
  input  logic [Y_W-1:0] y_max,
  input  logic [X_W-1:0] home_x,
  input  logic [Y_W-1:0] home_y,
  input  logic [5:0]     paddle_half,
  output logic [X_W-1:0] x_pos,
  output logic [Y_W-1:0] y_pos,
  output logic [3:0]     keys,
  output logic           moving
);

  // One extra bit over the wider axis so sums and differences never wrap.
  localparam int AW    = ((X_W > Y_W) ? X_W : Y_W) + 1;
  localparam int ACC_W = $clog2(ACC_MAX + 2);

  typedef enum logic {HOME, PLAY} state_t;

  state_t           state_q, state_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [3:0]       keys_q, keys_d;
  logic             brk_q, brk_d;
  logic             moving_q, moving_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [AW-1:0]    step;

  // Next coordinate on one axis; an empty window (lo > hi) pins the axis to lo.
  function automatic logic [AW-1:0] axis_next(
    input logic [AW-1:0] pos, mn, mx, half, stp,
    input logic          inc, dec
  );
    logic [AW-1:0] lo, hi, cand;
    lo   = mn + half;
    hi   = mx - half;
    cand = pos;
    if (mx < half || lo > hi) begin
      cand = lo;
    end else if (inc != dec) begin
      if (inc) cand = pos + stp;
      else     cand = (pos < stp) ? '0 : pos - stp;
      if (cand < lo)      cand = lo;
      else if (cand > hi) cand = hi;
    end
    return cand;
  endfunction

  always_comb begin
    state_d  = play_en ? PLAY : HOME;
    x_d      = x_q;
    y_d      = y_q;
    keys_d   = keys_q;
    brk_d    = brk_q;
    moving_d = 1'b0;
    acc_d    = acc_q;
    step     = (fast_mode ? AW'(SPD_FAST) : AW'(SPD_SLOW)) + AW'(acc_q);

    if (state_q == HOME || !play_en) begin
      x_d    = home_x;
      y_d    = home_y;
      keys_d = 4'b0000;
      brk_d  = 1'b0;
      acc_d  = '0;
    end else begin
      if (kb_valid) begin
        if (kb_code == 8'hF0) begin
          brk_d = 1'b1;
        end else if (kb_code != 8'hE0) begin
          brk_d = 1'b0;
          if (kb_code == KEY_UP) keys_d[3] = ~brk_q;
          if (kb_code == KEY_DN) keys_d[2] = ~brk_q;
          if (kb_code == KEY_LT) keys_d[1] = ~brk_q;
          if (kb_code == KEY_RT) keys_d[0] = ~brk_q;
        end
      end

      // Motion reads keys_q so a key arriving on the tick edge applies next frame.
      if (move_tick) begin
        x_d = X_W'(axis_next(AW'(x_q), AW'(x_min), AW'(x_max), AW'(paddle_half),
                             step, keys_q[0], keys_q[1]));
        y_d = Y_W'(axis_next(AW'(y_q), AW'(y_min), AW'(y_max), AW'(paddle_half),
                             step, keys_q[2], keys_q[3]));
        moving_d = (x_d != x_q) || (y_d != y_q);
`ifdef PADDLE_ACCEL_EN
        if (moving_d && (|keys_q))
          acc_d = (acc_q >= ACC_W'(ACC_MAX)) ? ACC_W'(ACC_MAX) : acc_q + ACC_W'(1);
        else
          acc_d = '0;
`else
        acc_d = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= HOME;
      x_q      <= home_x;
      y_q      <= home_y;
      keys_q   <= 4'b0000;
      brk_q    <= 1'b0;
      moving_q <= 1'b0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      keys_q   <= keys_d;
      brk_q    <= brk_d;
      moving_q <= moving_d;
      acc_q    <= acc_d;
    end
  end

  assign x_pos  = x_q;
  assign y_pos  = y_q;
  assign keys   = keys_q;
  assign moving = moving_q;

endmodule

// File: tb/tb_paddle_motion_ctrl.sv
// Directed bench for paddle_motion_ctrl; expectations follow the accel build when
// PADDLE_ACCEL_EN is defined.
module tb_paddle_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, kb_valid, move_tick, play_en, fast_mode;
  logic [7:0] kb_code;
  logic [9:0] x_min, x_max, home_x, x_pos;
  logic [8:0] y_min, y_max, home_y, y_pos;
  logic [5:0] paddle_half;
  logic [3:0] keys;
  logic       moving;
  int         tests = 0;
  int         fails = 0;

  paddle_motion_ctrl dut (
    .clk(clk), .rst_n(rst_n), .kb_code(kb_code), .kb_valid(kb_valid),
    .move_tick(move_tick), .play_en(play_en), .fast_mode(fast_mode),
    .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
    .home_x(home_x), .home_y(home_y), .paddle_half(paddle_half),
    .x_pos(x_pos), .y_pos(y_pos), .keys(keys), .moving(moving)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_key(input logic [7:0] c);
    kb_code  = c;
    kb_valid = 1'b1;
    step();
    kb_valid = 1'b0;
  endtask

  task automatic tick();
    move_tick = 1'b1;
    step();
    move_tick = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("[TB] %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  initial begin
    rst_n = 1'b0; kb_valid = 1'b0; kb_code = 8'h00; move_tick = 1'b0;
    play_en = 1'b0; fast_mode = 1'b0;
    x_min = 10'd0; x_max = 10'd320; y_min = 9'd0; y_max = 9'd480;
    home_x = 10'd160; home_y = 9'd240; paddle_half = 6'd16;
    step(); step();
    chk("rst_x", 16'(x_pos), 16'd160);
    chk("rst_y", 16'(y_pos), 16'd240);
    chk("rst_keys", 16'(keys), 16'd0);
    chk("rst_moving", 16'(moving), 16'd0);

    rst_n = 1'b1; play_en = 1'b1;
    step();
    chk("enter_play_x", 16'(x_pos), 16'd160);

    send_key(8'h1D);
    chk("press_up", 16'(keys), 16'b1000);

`ifdef PADDLE_ACCEL_EN
    tick(); chk("up_t1", 16'(y_pos), 16'd239);
    tick(); chk("up_t2", 16'(y_pos), 16'd237);
    tick(); chk("up_t3", 16'(y_pos), 16'd234);
    tick(); chk("up_t4", 16'(y_pos), 16'd230);
`else
    tick(); chk("up_t1", 16'(y_pos), 16'd239);
    tick(); chk("up_t2", 16'(y_pos), 16'd238);
    tick(); chk("up_t3", 16'(y_pos), 16'd237);
    tick(); chk("up_t4", 16'(y_pos), 16'd236);
`endif
    chk("moving_after_tick", 16'(moving), 16'd1);
    step();
    chk("moving_idle", 16'(moving), 16'd0);

    send_key(8'hF0);
    chk("break_pending", 16'(keys), 16'b1000);
    send_key(8'h1D);
    chk("release_up", 16'(keys), 16'b0000);
    tick();
`ifdef PADDLE_ACCEL_EN
    chk("no_move_released", 16'(y_pos), 16'd230);
`else
    chk("no_move_released", 16'(y_pos), 16'd236);
`endif
    chk("moving_released", 16'(moving), 16'd0);

    // Key press coinciding with a tick must not move on that tick.
    kb_code = 8'h1D; kb_valid = 1'b1; move_tick = 1'b1;
    step();
    kb_valid = 1'b0; move_tick = 1'b0;
`ifdef PADDLE_ACCEL_EN
    chk("coincide_y", 16'(y_pos), 16'd230);
`else
    chk("coincide_y", 16'(y_pos), 16'd236);
`endif
    chk("coincide_keys", 16'(keys), 16'b1000);
    chk("coincide_moving", 16'(moving), 16'd0);

    send_key(8'hE0); send_key(8'hF0); send_key(8'h1D);
    chk("ext_release", 16'(keys), 16'b0000);

    send_key(8'h1D); send_key(8'h1B); send_key(8'h23);
    chk("three_keys", 16'(keys), 16'b1101);
    tick();
    chk("diag_x", 16'(x_pos), 16'd161);
`ifdef PADDLE_ACCEL_EN
    chk("diag_y", 16'(y_pos), 16'd230);
`else
    chk("diag_y", 16'(y_pos), 16'd236);
`endif

    send_key(8'hF0); send_key(8'h1D); send_key(8'hF0); send_key(8'h1B);
    chk("rt_only", 16'(keys), 16'b0001);
    tick();
`ifdef PADDLE_ACCEL_EN
    chk("rt_move", 16'(x_pos), 16'd163);
`else
    chk("rt_move", 16'(x_pos), 16'd162);
`endif

    play_en = 1'b0; home_x = 10'd300;
    step();
    chk("drop_x", 16'(x_pos), 16'd300);
    chk("drop_y", 16'(y_pos), 16'd240);
    chk("drop_keys", 16'(keys), 16'd0);
    chk("drop_moving", 16'(moving), 16'd0);

    play_en = 1'b1;
    step();
    tick();
    chk("replay_nokey_x", 16'(x_pos), 16'd300);
    chk("replay_nokey_mv", 16'(moving), 16'd0);

    fast_mode = 1'b1;
    send_key(8'h23);
    tick();
    chk("fast_clamp_x", 16'(x_pos), 16'd304);
    chk("fast_clamp_mv", 16'(moving), 16'd1);
    tick();
    chk("held_clamp_x", 16'(x_pos), 16'd304);
    chk("held_clamp_mv", 16'(moving), 16'd0);

    x_max = 10'd20;
    tick();
    chk("empty_window_x", 16'(x_pos), 16'd16);
    chk("empty_window_mv", 16'(moving), 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/paddle_motion_ctrl.md
PADDLE_MOTION_CTRL -- requirements
Module: paddle_motion_ctrl

Interface
REQ-001 Parameters SHALL be, one per line, as follows.
- X_W, 10, x coordinate width.
- Y_W, 9, y coordinate width.
- KEY_UP, 8'h1D, make code for up.
- KEY_DN, 8'h1B, make code for down.
- KEY_LT, 8'h1C, make code for left.
- KEY_RT, 8'h23, make code for right.
- SPD_SLOW, 1, base step per tick in slow mode.
- SPD_FAST, 5, base step per tick in fast mode.
- ACC_MAX, 7, acceleration ceiling, in pixels.
REQ-002 Ports SHALL be, one per line, as follows.
- clk in 1: system clock.
- rst_n in 1: reset.
- kb_code in 8: keyboard scan byte.
- kb_valid in 1: one-cycle strobe qualifying kb_code.
- move_tick in 1: one-cycle motion enable, once per frame.
- play_en in 1: game running; low means hold at home.
- fast_mode in 1: selects SPD_FAST.
- x_min/x_max in X_W: player's field bounds in x.
- y_min/y_max in Y_W: player's field bounds in y.
- home_x in X_W, home_y in Y_W: start position.
- paddle_half in 6: paddle half-width.
- x_pos out X_W, y_pos out Y_W: paddle centre.
- keys out 4: held keys {up, dn, lt, rt}.
- moving out 1: a position changed on the last tick.
REQ-003 The block SHALL use one clock, clk; reset rst_n SHALL be synchronous and active-low.

Function
REQ-004 The controller SHALL have states HOME and PLAY: HOME->PLAY when play_en=1; PLAY->HOME when play_en=0; each transition takes effect on the next clk edge.
REQ-005 In HOME the block SHALL register x_pos=home_x, y_pos=home_y, keys=0, the acceleration level=0, moving=0, and a cleared break flag every cycle.
REQ-006 Key decode (PLAY only), for each kb_valid with kb_code as follows.
- 8'hF0: set the break flag.
- 8'hE0: ignored; the break flag is kept.
- Matching KEY_*: set that key bit, or clear it if the break flag is set; then clear the break flag.
- Any other code: clear the break flag only.
The updated keys SHALL be visible in the cycle after kb_valid.
REQ-007 Motion SHALL update only on a cycle with move_tick=1 in PLAY, using keys as registered before that edge; x_pos/y_pos SHALL be registered with 1-cycle latency.
REQ-008 step = (fast_mode ? SPD_FAST : SPD_SLOW) + acc_lvl, sampled on the tick.
REQ-009 up and dn held together SHALL give no y motion; lt and rt held together SHALL give no x motion; an x and a y key together SHALL move diagonally in the same tick.
REQ-010 Limits are lo = min + paddle_half and hi = max - paddle_half. A move SHALL clamp to [lo, hi] and SHALL never wrap; all arithmetic SHALL be computed at width+1 bits.
REQ-011 If lo > hi on an axis, the position on that axis SHALL be forced to lo.
REQ-012 moving SHALL be 1 for the cycle after a tick in which x_pos or y_pos changed, and 0 otherwise; a clamp with no change SHALL give moving=0.
REQ-013 If kb_valid and move_tick coincide, the motion SHALL use the keys from before that edge.
REQ-014 A drop of play_en in mid-motion SHALL return the block to home on the next edge with no partial step.

Reset
REQ-015 With rst_n=0 at a clk edge, the block SHALL enter HOME with all outputs at their REQ-005 values; x_pos=home_x and y_pos=home_y as sampled that cycle.
REQ-016 The first edge with rst_n=1 SHALL evaluate play_en normally.

Configuration
REQ-017 When macro PADDLE_ACCEL_EN is defined, acc_lvl SHALL behave as follows.
- It SHALL increment by 1 per tick on which a position changed, saturating at ACC_MAX.
- It SHALL clear on any tick where no direction key is held, or where no position changed.
REQ-018 When PADDLE_ACCEL_EN is undefined, acc_lvl SHALL be the constant 0 and step equals the base speed.

Verification
REQ-019 Reset, then play_en=1, fast_mode=0, home=(160,240), bounds x 0..320 and y 0..480, half=16; press 1D, then 4 ticks -> y_pos=236 without accel; with accel, y steps 1,2,3,4 give 230.
REQ-020 Hold rt with fast_mode=1 from x=300 -> x_pos=304 on the next tick and stays at 304; moving=0 afterwards.
REQ-021 Send F0,1D -> keys[3]=0 on the next cycle, and there is no y motion on later ticks; E0,F0,1D also releases the key.
REQ-022 Hold 1D+1B plus 23 for 1 tick in slow mode, no accel -> y unchanged, x+1.
REQ-023 Drop play_en in mid-hold -> the next cycle shows x/y=home, keys=0, acc_lvl=0; the next tick in PLAY gives no motion until a key is pressed again.
